point_link_arbiter: RTL and testbench
=====================================

POINT_LINK_ARBITER -- requirements
Module: point_link_arbiter

Interface
REQ-001 Parameter IDW, default 2, requester-id width; NREQ = 2**IDW requesters.
REQ-002 Parameter WIDTH, default 8, payload width per transaction.
REQ-003 Parameter TIMEOUT, default 16, response wait limit in clock cycles; legal range 2..65535.
REQ-004 Link word width LW = 1+IDW+WIDTH, format {valid, id, payload}; LW equals the WIDTH_O and WIDTH_I of the attached point-to-point master.
REQ-005 One clock; reset is asynchronous and active-high.
REQ-006 clock  input  1  bus-supplied clock; all logic on its rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 req  input  NREQ  per-requester request level.
REQ-009 req_data  input  NREQ*WIDTH  payloads; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-010 gnt  output  NREQ  one-hot, one-cycle grant pulse.
REQ-011 link_o  output  LW  word to the point master data_o input.
REQ-012 link_i  input  LW  word from the point master data_i output.
REQ-013 rsp_valid  output  NREQ  one-hot, one-cycle response pulse.
REQ-014 rsp_data  output  WIDTH  response payload, qualified by rsp_valid.
REQ-015 rsp_err  output  1  timeout flag, qualified by rsp_valid.
REQ-016 stray  output  1  one-cycle pulse on an unexpected link_i word.
REQ-017 busy  output  1  high while a transaction is outstanding.

Function
REQ-018 The FSM SHALL have states IDLE and WAIT, with one outstanding transaction at most.
REQ-019 IDLE with any req bit set at edge k: SHALL select winner w round-robin, searching from last_id+1 modulo NREQ.
REQ-020 After edge k: SHALL assert gnt[w] and link_o = {1, w, req_data[w]} for exactly one cycle, set busy, record w, enter WAIT.
REQ-021 link_o SHALL be all-zero in every cycle except the issue cycle.
REQ-022 WAIT, link_i valid=1 and id=w at edge m: after edge m SHALL pulse rsp_valid[w] with rsp_data = link_i payload and rsp_err=0.
REQ-023 On that response the FSM SHALL set last_id=w, clear busy and return to IDLE; the earliest next issue is one edge after the response.
REQ-024 link_i valid=1 with id != w in WAIT, or link_i valid=1 in IDLE: SHALL pulse stray, with no other effect.
REQ-025 rsp_data SHALL be zero whenever rsp_valid is zero.
REQ-026 Requester i SHALL hold req[i] until gnt[i]; a req still high after its response is treated as a new request.

Reset
REQ-027 Asserting reset SHALL immediately force gnt, link_o, rsp_valid, rsp_data, rsp_err, stray, busy and the timeout counter to 0, state to IDLE, and last_id to NREQ-1, so requester 0 has first priority.
REQ-028 Reset asserted in WAIT SHALL abandon the transaction with no response pulse; a later link_i word for it produces stray.

Configuration
REQ-029 With POINT_LINK_ARB_TIMEOUT_EN defined, a counter SHALL clear on entry to WAIT and increment each WAIT cycle.
REQ-030 When that counter reaches TIMEOUT-1 with no matching response: SHALL pulse rsp_valid[w] with rsp_err=1 and rsp_data=0, set last_id=w, and return to IDLE.
REQ-031 A matching response arriving at the same edge as the timeout SHALL win (rsp_err=0).
REQ-032 Without POINT_LINK_ARB_TIMEOUT_EN, no counter is built, rsp_err is tied 0, and WAIT persists until a matching response or reset.

Verification
REQ-033 Scenario: after reset, req=4'b0101, req_data[0]=8'hA5 -> one edge later gnt=4'b0001, link_o={1,2'd0,8'hA5} for one cycle; link_i={1,2'd0,8'h3C} -> rsp_valid=4'b0001, rsp_data=8'h3C.
REQ-034 Scenario: req=4'b1111 held, every response returned immediately -> grant order 0,1,2,3,0; busy drops for exactly one cycle between transactions.
REQ-035 Scenario: in WAIT for id 1, link_i={1,2'd2,8'h11} -> stray pulse, no rsp_valid, busy stays 1; then id 1 response completes normally.
REQ-036 Scenario: macro defined, TIMEOUT=16, no response -> rsp_valid[w]=1, rsp_err=1 on the 16th WAIT cycle; response on that same edge -> rsp_err=0 with payload.
REQ-037 Scenario: reset pulsed mid-WAIT -> all outputs 0 immediately; the late response yields stray, and the next grant goes to the lowest-numbered requester.
REQ-038 Scenario: macro undefined, no response for 1000 cycles -> busy stays 1, no rsp_valid, rsp_err constant 0.

Source files
------------

// File: rtl/point_link_arbiter.sv
// point_link_arbiter
//   Round-robin arbiter that funnels NREQ = 2**IDW requesters onto a single
//   point-to-point master link, one outstanding transaction at a time.
//   A winner's payload is issued as {valid, id, payload} on link_o for one
//   cycle. The matching {valid, id, payload} word returning on link_i is then
//   routed back to that requester as a one-cycle rsp_valid pulse.
//
//   Optional feature: define POINT_LINK_ARB_TIMEOUT_EN to build a response
//   timeout. A transaction that sees no matching response within TIMEOUT
//   cycles then completes with rsp_err=1 and rsp_data=0. Without the macro,
//   no counter is built, rsp_err stays 0 and the arbiter waits indefinitely.
//
// Ports
//   clock      rising-edge clock
//   reset      asynchronous active-high reset
//   req        per-requester request level (held until granted)
//   req_data   requester payloads, requester i at [i*WIDTH +: WIDTH]
//   gnt        one-hot one-cycle grant pulse
//   link_o     word to the point master (all-zero except in the issue cycle)
//   link_i     word from the point master
//   rsp_valid  one-hot one-cycle response pulse
//   rsp_data   response payload (zero unless rsp_valid)
//   rsp_err    timeout flag, qualified by rsp_valid
//   stray      one-cycle pulse on an unexpected link_i word
//   busy       high while a transaction is outstanding
module point_link_arbiter #(
  parameter int IDW     = 2,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 16,
  localparam int NREQ   = 2**IDW,
  localparam int LW     = 1 + IDW + WIDTH
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  output logic [NREQ-1:0]         gnt,
  output logic [LW-1:0]           link_o,
  input  logic [LW-1:0]           link_i,
  output logic [NREQ-1:0]         rsp_valid,
  output logic [WIDTH-1:0]        rsp_data,
  output logic                    rsp_err,
  output logic                    stray,
  output logic                    busy
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t           state_r, state_s;
  logic [IDW-1:0]   last_id_r, last_id_s;
  logic [IDW-1:0]   cur_id_r, cur_id_s;

  logic [NREQ-1:0]  gnt_s;
  logic [LW-1:0]    link_s;
  logic [NREQ-1:0]  rsp_valid_s;
  logic [WIDTH-1:0] rsp_data_s;
  logic             rsp_err_s;
  logic             stray_s;
  logic             busy_s;

  logic [IDW-1:0]   win_s;
  logic             found_s;
  logic [IDW-1:0]   idx_s;

  logic             link_valid_s;
  logic [IDW-1:0]   link_id_s;
  logic [WIDTH-1:0] link_pay_s;

`ifdef POINT_LINK_ARB_TIMEOUT_EN
  logic [15:0]      cnt_r, cnt_s;
`endif

  assign link_valid_s = link_i[LW-1];
  assign link_id_s    = link_i[WIDTH +: IDW];
  assign link_pay_s   = link_i[WIDTH-1:0];

  // Round-robin search: first set request starting at last_id+1, wrapping.
  // The index arithmetic wraps naturally because NREQ is a power of two.
  always_comb begin
    win_s   = '0;
    found_s = 1'b0;
    idx_s   = '0;
    for (int off = 1; off <= NREQ; off++) begin
      idx_s = last_id_r + IDW'(off);
      if (!found_s && req[idx_s]) begin
        win_s   = idx_s;
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Next-state and next-output logic for the IDLE/WAIT transaction FSM.
  always_comb begin
    state_s     = state_r;
    last_id_s   = last_id_r;
    cur_id_s    = cur_id_r;
    gnt_s       = '0;
    link_s      = '0;
    rsp_valid_s = '0;
    rsp_data_s  = '0;
    rsp_err_s   = 1'b0;
    stray_s     = 1'b0;
    busy_s      = busy;
`ifdef POINT_LINK_ARB_TIMEOUT_EN
    cnt_s       = cnt_r;
`endif
    case (state_r)
      ST_IDLE: begin
        // Nothing is outstanding, so any valid link word is unexpected.
        stray_s = link_valid_s;
`ifdef POINT_LINK_ARB_TIMEOUT_EN
        cnt_s   = 16'd0;
`endif
        if (found_s) begin
          state_s  = ST_WAIT;
          cur_id_s = win_s;
          gnt_s    = NREQ'(1) << win_s;
          link_s   = {1'b1, win_s, req_data[win_s*WIDTH +: WIDTH]};
          busy_s   = 1'b1;
        end else begin
          busy_s   = 1'b0;
        end
      end
      ST_WAIT: begin
        if (link_valid_s && (link_id_s == cur_id_r)) begin
          // A matching response wins even on the timeout edge.
          state_s     = ST_IDLE;
          last_id_s   = cur_id_r;
          rsp_valid_s = NREQ'(1) << cur_id_r;
          rsp_data_s  = link_pay_s;
          busy_s      = 1'b0;
        end else begin
          stray_s = link_valid_s;
`ifdef POINT_LINK_ARB_TIMEOUT_EN
          // cnt_r is 0 in the first WAIT cycle, so TIMEOUT-1 marks the
          // last cycle the response is allowed to arrive in.
          if (cnt_r == 16'(TIMEOUT - 1)) begin
            state_s     = ST_IDLE;
            last_id_s   = cur_id_r;
            rsp_valid_s = NREQ'(1) << cur_id_r;
            rsp_err_s   = 1'b1;
            busy_s      = 1'b0;
          end else begin
            cnt_s       = cnt_r + 16'd1;
            busy_s      = 1'b1;
          end
`else
          busy_s = 1'b1;
`endif
        end
      end
      default: begin
        state_s = ST_IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State, arbitration history and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      last_id_r <= IDW'(NREQ - 1);
      cur_id_r  <= '0;
      gnt       <= '0;
      link_o    <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      stray     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_r   <= state_s;
      last_id_r <= last_id_s;
      cur_id_r  <= cur_id_s;
      gnt       <= gnt_s;
      link_o    <= link_s;
      rsp_valid <= rsp_valid_s;
      rsp_data  <= rsp_data_s;
      rsp_err   <= rsp_err_s;
      stray     <= stray_s;
      busy      <= busy_s;
    end
  end

`ifdef POINT_LINK_ARB_TIMEOUT_EN
  // Response wait counter, cleared while idle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_r <= 16'd0;
    end else begin
      cnt_r <= cnt_s;
    end
  end
`endif

endmodule

// File: tb/tb_point_link_arbiter.sv
module tb_point_link_arbiter;
  localparam int IDW     = 2;
  localparam int WIDTH   = 8;
  localparam int TIMEOUT = 16;
  localparam int NREQ    = 4;
  localparam int LW      = 11;

  logic             clock = 1'b0;
  logic             reset;
  logic [NREQ-1:0]  req;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]  gnt;
  logic [LW-1:0]    link_o;
  logic [LW-1:0]    link_i;
  logic [NREQ-1:0]  rsp_valid;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_err;
  logic             stray;
  logic             busy;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit m_busy;
  int m_id;
  int m_last;
  int m_age;
  logic [NREQ-1:0]  e_gnt, e_rv;
  logic [LW-1:0]    e_link;
  logic [WIDTH-1:0] e_rd;
  logic             e_err, e_stray, e_busy;

  point_link_arbiter #(.IDW(IDW), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .req(req), .req_data(req_data),
    .gnt(gnt), .link_o(link_o), .link_i(link_i), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .stray(stray), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_last = NREQ - 1; m_age = 0; m_id = 0;
    e_gnt = '0; e_rv = '0; e_link = '0; e_rd = '0;
    e_err = 1'b0; e_stray = 1'b0; e_busy = 1'b0;
  endtask

  // Applies the arbiter's rules for one rising edge to the current inputs.
  task automatic model_edge();
    logic lv;
    int   lid;
    logic [WIDTH-1:0] lp;
    int   w;
    lv  = link_i[LW-1];
    lid = int'(link_i[WIDTH +: IDW]);
    lp  = link_i[WIDTH-1:0];
    e_gnt = '0; e_rv = '0; e_link = '0; e_rd = '0;
    e_err = 1'b0; e_stray = 1'b0;
    if (!m_busy) begin
      e_stray = lv;
      if (req != 4'b0000) begin
        w = -1;
        for (int off = 1; off <= NREQ; off++)
          if (w < 0 && req[(m_last + off) % NREQ]) w = (m_last + off) % NREQ;
        e_gnt  = 4'b0001 << w;
        e_link = {1'b1, 2'(w), req_data[w*WIDTH +: WIDTH]};
        m_busy = 1'b1; m_id = w; m_age = 0;
      end
    end else begin
      m_age++;
      if (lv && lid == m_id) begin
        e_rv = 4'b0001 << m_id; e_rd = lp; m_last = m_id; m_busy = 1'b0;
      end else begin
        e_stray = lv;
`ifdef POINT_LINK_ARB_TIMEOUT_EN
        if (m_age >= TIMEOUT) begin
          e_rv = 4'b0001 << m_id; e_err = 1'b1; m_last = m_id; m_busy = 1'b0;
        end
`endif
      end
    end
    e_busy = m_busy;
  endtask

  task automatic check_all(string tag);
    chk({tag, ".gnt"},       32'(gnt),       32'(e_gnt));
    chk({tag, ".link_o"},    32'(link_o),    32'(e_link));
    chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'(e_rv));
    chk({tag, ".rsp_data"},  32'(rsp_data),  32'(e_rd));
    chk({tag, ".rsp_err"},   32'(rsp_err),   32'(e_err));
    chk({tag, ".stray"},     32'(stray),     32'(e_stray));
    chk({tag, ".busy"},      32'(busy),      32'(e_busy));
  endtask

  task automatic tick(string tag);
    model_edge();
    @(posedge clock);
    #1;
    check_all(tag);
  endtask

  // Reset pulse raised between edges; outputs must clear without a clock.
  task automatic do_reset(string tag);
    reset = 1'b1;
    model_reset();
    #2;
    check_all(tag);
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req = '0; req_data = '0; link_i = '0;
    model_reset();
    #2;
    check_all("reset");
    @(posedge clock); #1;
    reset = 1'b0;

    // basic issue / response
    req = 4'b0101; req_data = 32'h0000_00A5;
    tick("s1_issue");
    chk("s1_gnt", 32'(gnt), 32'h1);
    chk("s1_link", 32'(link_o), 32'h4A5);
    req = 4'b0100;
    link_i = {1'b1, 2'd0, 8'h3C};
    tick("s1_rsp");
    chk("s1_rv", 32'(rsp_valid), 32'h1);
    chk("s1_rd", 32'(rsp_data), 32'h3C);
    link_i = '0;
    tick("s1_issue2");
    chk("s1_gnt2", 32'(gnt), 32'h4);
    req = '0;
    link_i = {1'b1, 2'd2, 8'hC7};
    tick("s1_rsp2");
    link_i = '0;
    tick("s1_idle");

    // round robin with all requesters held
    do_reset("s2_reset");
    req = 4'b1111; req_data = 32'h4433_2211;
    for (int n = 0; n < 5; n++) begin
      tick("s2_issue");
      chk("s2_order", 32'(gnt), 32'(4'b0001 << (n % 4)));
      link_i = {1'b1, 2'(n % 4), 8'(n + 8'h50)};
      tick("s2_rsp");
      chk("s2_busy_drop", 32'(busy), 32'h0);
      link_i = '0;
    end
    req = '0;
    tick("s2_idle");

    // stray word while waiting
    do_reset("s3_reset");
    req = 4'b0010; req_data = 32'h0000_9900;
    tick("s3_issue");
    chk("s3_gnt", 32'(gnt), 32'h2);
    req = '0;
    link_i = {1'b1, 2'd2, 8'h11};
    tick("s3_stray");
    chk("s3_stray_pulse", 32'(stray), 32'h1);
    chk("s3_busy", 32'(busy), 32'h1);
    link_i = {1'b1, 2'd1, 8'h55};
    tick("s3_rsp");
    chk("s3_rv", 32'(rsp_valid), 32'h2);
    chk("s3_rd", 32'(rsp_data), 32'h55);
    link_i = '0;
    tick("s3_idle");

    // reset in the middle of a transaction
    do_reset("s5_reset");
    req = 4'b0100; req_data = 32'h00AB_0000;
    tick("s5_issue");
    req = '0;
    tick("s5_wait");
    reset = 1'b1;
    model_reset();
    #2;
    check_all("s5_midreset");
    chk("s5_link_zero", 32'(link_o), 32'h0);
    reset = 1'b0;
    link_i = {1'b1, 2'd2, 8'h77};
    tick("s5_late");
    chk("s5_late_stray", 32'(stray), 32'h1);
    link_i = '0;
    req = 4'b1010; req_data = 32'h1200_3400;
    tick("s5_next");
    chk("s5_next_gnt", 32'(gnt), 32'h2);
    req = 4'b1000;
    link_i = {1'b1, 2'd1, 8'h01};
    tick("s5_rsp");
    link_i = '0; req = '0;
    tick("s5_issue3");
    link_i = {1'b1, 2'd3, 8'h02};
    tick("s5_rsp3");
    link_i = '0;

`ifdef POINT_LINK_ARB_TIMEOUT_EN
    // timeout, then a response arriving on the timeout edge
    do_reset("s4_reset");
    req = 4'b0001; req_data = 32'h0000_00EE;
    tick("s4_issue");
    req = '0;
    for (int n = 0; n < TIMEOUT - 1; n++) tick("s4_wait");
    tick("s4_timeout");
    chk("s4_to_rv", 32'(rsp_valid), 32'h1);
    chk("s4_to_err", 32'(rsp_err), 32'h1);
    chk("s4_to_rd", 32'(rsp_data), 32'h0);
    req = 4'b0010;
    tick("s4_issue2");
    req = '0;
    for (int n = 0; n < TIMEOUT - 1; n++) tick("s4_wait2");
    link_i = {1'b1, 2'd1, 8'h99};
    tick("s4_race");
    chk("s4_race_rv", 32'(rsp_valid), 32'h2);
    chk("s4_race_err", 32'(rsp_err), 32'h0);
    chk("s4_race_rd", 32'(rsp_data), 32'h99);
    link_i = '0;
`else
    // no response ever: wait persists
    do_reset("s6_reset");
    req = 4'b0001; req_data = 32'h0000_0042;
    tick("s6_issue");
    req = '0;
    for (int n = 0; n < 1000; n++) tick("s6_wait");
    chk("s6_busy", 32'(busy), 32'h1);
    chk("s6_err", 32'(rsp_err), 32'h0);
`endif

    // randomized traffic against the model
    do_reset("rand_reset");
    for (int c = 0; c < 3000; c++) begin
      int r;
      for (int i = 0; i < NREQ; i++)
        if (!req[i] && $urandom_range(0, 2) == 0) begin
          req[i] = 1'b1;
          req_data[i*WIDTH +: WIDTH] = 8'($urandom);
        end
      r = $urandom_range(0, 9);
      if (m_busy && r < 4) link_i = {1'b1, 2'(m_id), 8'($urandom)};
      else if (r == 4)     link_i = {1'b1, 2'($urandom), 8'($urandom)};
      else                 link_i = '0;
      if (c % 700 == 350) do_reset("rand_midreset");
      else tick("rand");
      for (int i = 0; i < NREQ; i++)
        if (e_gnt[i] && $urandom_range(0, 1) == 0) req[i] = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
